frame_checker_mc: RTL

- Next-generation receive-side test-frame checker.
- Sits between the MAC RX AXIS stream and the router datapath.
- Recognises IPv4 test frames on their first beat only, drops them from the stream, and checks the IP header checksum and the LFSR payload.
- Accumulates per-channel results, banked by axis_s_id, under a start/stop/drain control FSM; other frames pass through unchanged.

---
 rtl/frame_checker_mc_pkg.sv | 49 ++++
 rtl/frame_checker_mc_if.sv | 12 +
 rtl/frame_checker_mc_bank.sv | 43 ++++
 rtl/frame_checker_mc.sv | 113 +++++++++++
 4 files changed

// File: rtl/frame_checker_mc_pkg.sv
// frame_checker_mc_pkg: shared types, constants and header/LFSR helpers for the test-frame checker.
package frame_checker_mc_pkg;
    typedef logic [15:0] u16_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} checker_state_t;
    localparam logic [7:0] TEST_FRAME_TOS   = 8'h04;
    localparam logic [7:0] TEST_FRAME_PROTO = 8'hFD;
    typedef struct packed {
        logic [31:0] err_bytes;
        logic [31:0] err_frames;
        logic [31:0] recv_bytes;
        logic [31:0] recv_frames;
    } port_result_t;
    // Byte 0 of the wire sits at bit 0, so multi-byte fields hold network-order bytes reversed.
    typedef struct packed {
        logic [31:0] dst_ip;
        logic [31:0] src_ip;
        u16_t        csum;
        logic [7:0]  proto;
        logic [7:0]  ttl;
        u16_t        frag;
        u16_t        id;
        u16_t        total_len;
        logic [7:0]  tos;
        logic [7:0]  ver_ihl;
        u16_t        ethertype;
        logic [47:0] src_mac;
        logic [47:0] dst_mac;
    } frame_header_t;
    function automatic u16_t lfsr16_next(u16_t l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction
    function automatic u16_t swap16(u16_t v);
        return {v[7:0], v[15:8]};
    endfunction
    // One's-complement sums are byte-order agnostic, so the raw words compare directly to the raw field.
    function automatic u16_t ip_header_checksum(frame_header_t h);
        logic [19:0] s;
        s = 20'({h.tos, h.ver_ihl}) + 20'(h.total_len) + 20'(h.id) + 20'(h.frag) + 20'({h.proto, h.ttl})
          + 20'(h.src_ip[15:0]) + 20'(h.src_ip[31:16]) + 20'(h.dst_ip[15:0]) + 20'(h.dst_ip[31:16]);
        s = 20'(s[15:0]) + 20'(s[19:16]);
        s = 20'(s[15:0]) + 20'(s[19:16]);
        return ~s[15:0];
    endfunction
    function automatic logic [31:0] sat_add(logic [31:0] a, logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction
endpackage

// File: rtl/frame_checker_mc_if.sv
// frame_checker_mc_if: AXI-stream bundle with master/slave views.
interface frame_checker_mc_if #(parameter int DATA_WIDTH = 512, parameter int ID_WIDTH = 3);
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic                    last;
    logic [DATA_WIDTH/8-1:0] user;
    logic [ID_WIDTH-1:0]     id;
    logic                    valid;
    logic                    ready;
    modport master(output data, keep, last, user, id, valid, input ready);
    modport slave(input data, keep, last, user, id, valid, output ready);
endinterface

// File: rtl/frame_checker_mc_bank.sv
// frame_checker_bank: per-channel result registers with saturating update and registered read.
module frame_checker_bank
    import frame_checker_mc_pkg::*;
#(
    parameter int ID_WIDTH     = 3,
    parameter int NUM_CHANNELS = 2**ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_upd,
    input  logic                i_ok,
    input  logic [ID_WIDTH-1:0] i_idx,
    input  u16_t                i_bytes,
    input  logic [ID_WIDTH-1:0] i_sel,
    output port_result_t        o_result
);
    port_result_t r_bank [NUM_CHANNELS];
    port_result_t w_upd;
    always_comb begin
        w_upd = r_bank[i_idx];
        if (i_ok) begin
            w_upd.recv_frames = sat_add(w_upd.recv_frames, 32'd1);
            w_upd.recv_bytes  = sat_add(w_upd.recv_bytes, 32'(i_bytes));
        end else begin
            w_upd.err_frames = sat_add(w_upd.err_frames, 32'd1);
            w_upd.err_bytes  = sat_add(w_upd.err_bytes, 32'(i_bytes));
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) r_bank[i] <= '0;
            o_result <= '0;
        end else begin
            if (i_clear) begin
                for (int i = 0; i < NUM_CHANNELS; i++) r_bank[i] <= '0;
            end else if (i_upd) begin
                r_bank[i_idx] <= w_upd;
            end
            o_result <= r_bank[i_sel];
        end
    end
endmodule

// File: rtl/frame_checker_mc.sv
// frame_checker_mc: drops IPv4 test frames from the RX stream and banks their check results per id.
// Optional length check against IP total_length is built when FRAME_CHECKER_LEN_CHECK_EN is defined.
module frame_checker_mc
    import frame_checker_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 512,
    parameter int ID_WIDTH     = 3,
    parameter int NUM_CHANNELS = 2**ID_WIDTH,
    parameter int HDR_BYTES    = 34
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                o_ready,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [ID_WIDTH-1:0] i_result_sel,
    output port_result_t        o_result,
    frame_checker_mc_if.slave   s_axis,
    frame_checker_mc_if.master  m_axis
);
    localparam int KW = DATA_WIDTH / 8;
    localparam logic [KW-1:0] PAY_MASK = {KW{1'b1}} << HDR_BYTES;
    checker_state_t r_state, w_state_nxt;
    logic r_in_frame, r_is_test, r_counted, r_err;
    logic [ID_WIDTH-1:0] r_id, w_id;
    u16_t r_lfsr, r_sum, w_pat, w_sum;
    frame_header_t w_hdr;
    logic [16:0] w_sum_raw;
    logic [KW-1:0] w_mask;
    logic w_first, w_xfer, w_is_test, w_cnt, w_clr, w_active, w_acct, w_bad, w_err, w_len_bad;
    assign w_hdr     = frame_header_t'(s_axis.data[$bits(frame_header_t)-1:0]);
    assign w_first   = !r_in_frame;
    assign w_xfer    = s_axis.valid && s_axis.ready;
    assign w_is_test = w_first ? (swap16(w_hdr.ethertype) == 16'h0800 && w_hdr.ver_ihl == 8'h45 &&
                                  w_hdr.tos == TEST_FRAME_TOS && w_hdr.proto == TEST_FRAME_PROTO) : r_is_test;
    assign w_pat     = w_first ? w_hdr.id : r_lfsr;
    assign w_id      = w_first ? s_axis.id : r_id;
    assign w_cnt     = w_first ? (r_state == RUN && 32'(s_axis.id) < NUM_CHANNELS) : r_counted;
    assign w_clr     = i_start && r_state != DRAIN;
    assign w_mask    = s_axis.keep & (w_first ? PAY_MASK : {KW{1'b1}});
    assign w_sum_raw = {1'b0, w_first ? 16'd0 : r_sum} + 17'($countones(s_axis.keep));
    assign w_sum     = w_sum_raw[16] ? 16'hFFFF : w_sum_raw[15:0];
    assign w_err     = (!w_first && r_err) || w_bad || w_len_bad;
    assign w_acct    = w_xfer && s_axis.last && w_is_test && w_cnt && !w_clr;
    // A counted test frame is still open after this cycle: decides DRAIN versus IDLE on stop.
    assign w_active  = w_xfer ? (!s_axis.last && w_is_test && w_cnt) : (r_in_frame && r_is_test && r_counted);
    assign m_axis.data  = s_axis.data;
    assign m_axis.keep  = s_axis.keep;
    assign m_axis.last  = s_axis.last;
    assign m_axis.user  = s_axis.user;
    assign m_axis.id    = s_axis.id;
    assign m_axis.valid = rst_n && s_axis.valid && !w_is_test;
    assign s_axis.ready = rst_n && (w_is_test || m_axis.ready);
    always_comb begin
        w_bad = |s_axis.user || |(s_axis.keep & (s_axis.keep + KW'(1))) ||
                (w_first && ip_header_checksum(w_hdr) != w_hdr.csum);
        for (int i = 0; i < KW; i++)
            if (w_mask[i] && s_axis.data[8*i +: 8] != w_pat[8*(i%2) +: 8]) w_bad = 1'b1;
    end
`ifdef FRAME_CHECKER_LEN_CHECK_EN
    logic [16:0] r_exp_len, w_exp_len;
    assign w_exp_len = w_first ? 17'(swap16(w_hdr.total_len)) + 17'd14 : r_exp_len;
    assign w_len_bad = s_axis.last && {1'b0, w_sum} != w_exp_len;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_exp_len <= '0;
        else if (w_xfer) r_exp_len <= w_exp_len;
    end
`else
    assign w_len_bad = 1'b0;
`endif
    always_comb begin
        w_state_nxt = r_state;
        o_ready     = r_state != DRAIN;
        if (r_state == IDLE && i_start) w_state_nxt = RUN;
        else if (r_state == RUN && i_stop && !i_start) w_state_nxt = w_active ? DRAIN : IDLE;
        else if (r_state == DRAIN && w_xfer && s_axis.last) w_state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_frame <= 1'b0;
            r_is_test  <= 1'b0;
            r_counted  <= 1'b0;
            r_err      <= 1'b0;
            r_id       <= '0;
            r_lfsr     <= '0;
            r_sum      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_in_frame <= !s_axis.last;
                r_is_test  <= w_is_test;
                r_lfsr     <= lfsr16_next(w_pat);
                r_id       <= w_id;
                r_sum      <= w_sum;
                r_err      <= w_err;
            end
            if (w_clr) r_counted <= 1'b0;
            else if (w_xfer) r_counted <= w_cnt;
        end
    end
    frame_checker_bank #(.ID_WIDTH(ID_WIDTH), .NUM_CHANNELS(NUM_CHANNELS)) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clr),
        .i_upd    (w_acct),
        .i_ok     (!w_err),
        .i_idx    (w_id),
        .i_bytes  (w_sum),
        .i_sel    (i_result_sel),
        .o_result (o_result)
    );
endmodule
